fixed_sample_capture: RTL and testbench

- Capture side of an msdsl model testbench: samples a model's signed fixed-point output every clock, waits for a rising threshold crossing, then records NUM_SAMPLES decimated samples.
- Recorded samples go into an internal FIFO and are streamed out on a valid/ready interface for checking or export.
- Sits between the model instance's output port and the bench's checker.
- Carries raw fixed-point words only; the binary point (EXPONENT) travels as metadata.

---
 rtl/fixed_sample_capture.sv | 174 +++++++++++++++++
 tb/tb_fixed_sample_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_sample_capture.sv
// Threshold-triggered, decimating capture of a signed fixed-point stream into a
// first-word-fall-through FIFO drained over a valid/ready interface.
module fixed_sample_capture #(
    parameter int WIDTH       = 16,
    parameter int EXPONENT    = -10,
    parameter int DEPTH       = 16,
    parameter int NUM_SAMPLES = 32,
    parameter int DECIM_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic [DECIM_W-1:0] decim,
    input  logic [WIDTH-1:0]   threshold,
    input  logic [WIDTH-1:0]   sample_in,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int  AW         = $clog2(DEPTH);
    localparam int  CW         = $clog2(NUM_SAMPLES + 1);
    localparam bit  SingleShot = (NUM_SAMPLES == 1);

    // The binary point is carried only as metadata; reject nonsensical configurations early.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_SAMPLES < 1 ||
        EXPONENT < -64 || EXPONENT > 64) begin : g_bad_cfg
        $error("fixed_sample_capture: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q;
    logic               prev_valid_q, prev_valid_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0]      rcnt_q, rcnt_d;
    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic signed [WIDTH-1:0] thr_s, smp_s, prev_s;
    logic                    trig;
    logic                    wr_req, wr_en, pop, full, empty;

    assign thr_s  = $signed(threshold);
    assign smp_s  = $signed(sample_in);
    assign prev_s = $signed(prev_q);
    assign trig   = prev_valid_q && (prev_s < thr_s) && (smp_s >= thr_s);

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
    assign wr_en = wr_req && (!full || pop);

    always_comb begin
        state_d      = state_q;
        prev_valid_d = prev_valid_q;
        decim_d      = decim_q;
        dcnt_d       = dcnt_q;
        rcnt_d       = rcnt_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        wr_req       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d      = ARMED;
                    overflow_d   = 1'b0;
                    prev_valid_d = 1'b0;
                end
            end
            ARMED: begin
                prev_valid_d = 1'b1;
                if (trig) begin
                    wr_req  = 1'b1;
                    decim_d = decim;
                    dcnt_d  = '0;
                    rcnt_d  = CW'(1);
                    state_d = SingleShot ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (dcnt_q == decim_q) begin
                    wr_req = 1'b1;
                    dcnt_d = '0;
                    rcnt_d = rcnt_q + CW'(1);
                    if (rcnt_q == CW'(NUM_SAMPLES - 1)) begin
                        state_d = DRAIN;
                    end
                end else begin
                    dcnt_d = dcnt_q + DECIM_W'(1);
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropped samples still count toward NUM_SAMPLES to keep the timebase intact.
        if (wr_req && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + (AW + 1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            prev_valid_q <= 1'b0;
            decim_q      <= '0;
            dcnt_q       <= '0;
            rcnt_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= prev_valid_d;
            decim_q      <= decim_d;
            dcnt_q       <= dcnt_d;
            rcnt_q       <= rcnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    // Sample history and FIFO storage are data only; prev_valid_q gates any use of stale prev_q.
    always_ff @(posedge clk) begin
        if (state_q == ARMED) begin
            prev_q <= sample_in;
        end
        if (wr_en) begin
            mem[wptr_q[AW-1:0]] <= sample_in;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rptr_q[AW-1:0]];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_sample_capture.sv
// Scoreboard bench for fixed_sample_capture: directed runs push hand-computed
// expected samples; a negedge monitor pops and compares on every accepted beat.
module tb_fixed_sample_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [7:0]  decim;
    logic [15:0] threshold;
    logic [15:0] sample_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic        done_prev = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fixed_sample_capture #(
        .WIDTH(16), .EXPONENT(-10), .DEPTH(16), .NUM_SAMPLES(32), .DECIM_W(8)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .decim(decim), .threshold(threshold),
        .sample_in(sample_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no output", out_data);
                end else begin
                    chk("beat_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
                end
            end
            if (done) begin
                done_cnt++;
                if (done_prev) chk("done_one_cycle", 32'd1, 32'd0);
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [15:0] v);
        sample_in = v;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic push_ramp(input int start, input int step, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(16'(start + k * step));
    endtask

    task automatic run_until_done(input logic [15:0] v0, input int inc, input int budget,
                                  input string name, input logic exp_ovf);
        int d0;
        int n;
        logic [15:0] v;
        d0 = done_cnt;
        n  = 0;
        v  = v0;
        while (done_cnt == d0 && n < budget) begin
            sample_in = v;
            v = v + 16'(inc);
            tick();
            n++;
        end
        repeat (4) tick();
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_left_in_q"}, exp_q.size(), 0);
        chk({name, "_busy_after"}, {31'h0, busy}, 0);
        chk({name, "_valid_after"}, {31'h0, out_valid}, 0);
        chk({name, "_overflow"}, {31'h0, overflow}, {31'h0, exp_ovf});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; arm = 1'b0; decim = 8'd0; threshold = 16'h0200;
        sample_in = 16'h0; out_ready = 1'b1;
        #12;
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_data", {16'h0, out_data}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        tick();
        rst = 1'b1;
        tick();

        // Basic step capture: 0x0000 -> 0x0400 across threshold 0x0200
        push_ramp(16'h0400, 0, 32);
        do_arm(16'h0000);
        chk("step_busy_armed", {31'h0, busy}, 1);
        sample_in = 16'h0000; tick();
        sample_in = 16'h0000; tick();
        run_until_done(16'h0400, 0, 200, "step", 1'b0);

        // No false trigger while held above threshold
        sample_in = 16'h0400;
        repeat (3) tick();
        do_arm(16'h0400);
        for (int i = 0; i < 20; i++) begin
            sample_in = 16'h0400;
            tick();
            chk("hold_valid", {31'h0, out_valid}, 0);
        end
        chk("hold_busy", {31'h0, busy}, 1);
        push_ramp(16'h0400, 0, 32);
        sample_in = 16'h0000; tick();
        run_until_done(16'h0400, 0, 200, "rearm_rise", 1'b0);

        // Decimation by 3 on a ramp crossing 10
        threshold = 16'd10; decim = 8'd2;
        push_ramp(10, 3, 32);
        do_arm(16'd0);
        run_until_done(16'd1, 1, 400, "decim", 1'b0);

        // Backpressure: first 16 retained, remaining 16 dropped
        threshold = 16'd100; decim = 8'd0; out_ready = 1'b0;
        push_ramp(100, 1, 16);
        do_arm(16'd90);
        for (int v = 91; v <= 150; v++) begin
            sample_in = 16'(v);
            tick();
        end
        chk("bp_head_stable", {16'h0, out_data}, 100);
        chk("bp_valid", {31'h0, out_valid}, 1);
        chk("bp_overflow", {31'h0, overflow}, 1);
        chk("bp_busy_drain", {31'h0, busy}, 1);
        out_ready = 1'b1;
        run_until_done(16'd151, 1, 100, "bp", 1'b1);

        // Full FIFO with simultaneous pop: every write accepted
        out_ready = 1'b0;
        do_arm(16'd90);
        chk("arm_clears_overflow", {31'h0, overflow}, 0);
        push_ramp(100, 1, 32);
        for (int v = 91; v <= 131; v++) begin
            sample_in = 16'(v);
            out_ready = (v >= 116);
            if (v == 116) chk("full_valid", {31'h0, out_valid}, 1);
            tick();
        end
        chk("fullpop_overflow", {31'h0, overflow}, 0);
        run_until_done(16'd132, 1, 100, "fullpop", 1'b0);

        // Asynchronous reset in the middle of a capture
        out_ready = 1'b0;
        do_arm(16'd90);
        for (int v = 91; v <= 105; v++) begin
            sample_in = 16'(v);
            tick();
        end
        chk("pre_reset_valid", {31'h0, out_valid}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 0);
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_done", {31'h0, done}, 0);
        chk("arst_data", {16'h0, out_data}, 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        push_ramp(100, 1, 32);
        do_arm(16'd90);
        run_until_done(16'd91, 1, 200, "post_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
